// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX stage bus: decoded ID operands in, registered EX operands and stall out
//
// master: the ID/EX environment (drives id_*, observes stall and ex_*)
// slave : the id_ex_stage register itself (consumes id_*, drives stall and ex_*)
//   id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm   decoded instruction from ID
//   id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2     register indices and usage flags
//   id_ctrl  {reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src, alu_op[2:0]}
//   stall    combinational load-use stall to PC and IF/ID
//   ex_*     registered copies presented to EX and the forwarding unit
interface id_ex_stage_if #(
    parameter int XLEN = 64
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            id_uses_rs1;
    logic            id_uses_rs2;
    logic [8:0]      id_ctrl;

    logic            stall;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [8:0]      ex_ctrl;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, id_ctrl,
        input  stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_ctrl
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, id_ctrl,
        output stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_ctrl
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection and bubble insertion
//
// Ports:
//   clk, rst_n   core clock (rising edge), asynchronous active-low reset
//   bus          id_ex_stage_if.slave: ID operands in, stall and EX operands out
//   flush        taken branch/jump resolved downstream; the ID instruction becomes a bubble
//   hold         global freeze; every register keeps its value
//   stall_count  saturating count of inserted load-use bubbles
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_stage_if.slave     bus,
    input  logic             flush,
    input  logic             hold,
    output logic [CNT_W-1:0] stall_count
);
    // Control bundle bit positions
    localparam int CTRL_MEM_READ = 7;

    logic             ex_valid_q,    ex_valid_d;
    logic [XLEN-1:0]  ex_pc_q,       ex_pc_d;
    logic [XLEN-1:0]  ex_rs1_data_q, ex_rs1_data_d;
    logic [XLEN-1:0]  ex_rs2_data_q, ex_rs2_data_d;
    logic [XLEN-1:0]  ex_imm_q,      ex_imm_d;
    logic [4:0]       ex_rs1_q,      ex_rs1_d;
    logic [4:0]       ex_rs2_q,      ex_rs2_d;
    logic [4:0]       ex_rd_q,       ex_rd_d;
    logic [8:0]       ex_ctrl_q,     ex_ctrl_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic load_use;
    logic rs1_hit;
    logic rs2_hit;

    // A load in EX whose result an ID reader needs cannot be forwarded in time.
    // Loads to x0 are excluded since x0 is never written.
    always_comb begin
        rs1_hit  = bus.id_uses_rs1 && (bus.id_rs1 == ex_rd_q);
        rs2_hit  = bus.id_uses_rs2 && (bus.id_rs2 == ex_rd_q);
        load_use = ex_valid_q && ex_ctrl_q[CTRL_MEM_READ] && (ex_rd_q != 5'd0) &&
                   (rs1_hit || rs2_hit) && bus.id_valid;
    end

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_pc_d       = ex_pc_q;
        ex_rs1_data_d = ex_rs1_data_q;
        ex_rs2_data_d = ex_rs2_data_q;
        ex_imm_d      = ex_imm_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rd_d       = ex_rd_q;
        ex_ctrl_d     = ex_ctrl_q;
        stall_count_d = stall_count_q;

        if (!hold) begin
            // Data fields always track ID so bubble contents stay deterministic.
            ex_pc_d       = bus.id_pc;
            ex_rs1_data_d = bus.id_rs1_data;
            ex_rs2_data_d = bus.id_rs2_data;
            ex_imm_d      = bus.id_imm;
            ex_rs1_d      = bus.id_rs1;
            ex_rs2_d      = bus.id_rs2;
            ex_rd_d       = bus.id_rd;

            if (flush || load_use) begin
                // Zero ctrl guarantees reg_write=0 and mem_read=0 downstream.
                ex_valid_d = 1'b0;
                ex_ctrl_d  = 9'd0;
            end else begin
                ex_valid_d = bus.id_valid;
                ex_ctrl_d  = bus.id_valid ? bus.id_ctrl : 9'd0;
            end

            if (!flush && load_use && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_rs1_q      <= 5'd0;
            ex_rs2_q      <= 5'd0;
            ex_rd_q       <= 5'd0;
            ex_ctrl_q     <= 9'd0;
            stall_count_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            ex_ctrl_q     <= ex_ctrl_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Stall is independent of hold so PC and IF/ID stay frozen across a freeze.
    assign bus.stall       = load_use && !flush;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_pc       = ex_pc_q;
    assign bus.ex_rs1_data = ex_rs1_data_q;
    assign bus.ex_rs2_data = ex_rs2_data_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_rs1      = ex_rs1_q;
    assign bus.ex_rs2      = ex_rs2_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_ctrl     = ex_ctrl_q;
    assign stall_count     = stall_count_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
    localparam int XLEN  = 64;
    localparam int CNT_W = 2;   // narrow counter so saturation is reachable

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             hold;
    logic [CNT_W-1:0] stall_count;

    int total;
    int bad;

    id_ex_stage_if #(.XLEN(XLEN)) bus ();

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .flush       (flush),
        .hold        (hold),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                          input logic u2, input logic [8:0] ctrl);
        bus.id_valid    = v;
        bus.id_pc       = pc;
        bus.id_rs1_data = pc ^ 64'hA5A5;
        bus.id_rs2_data = pc ^ 64'h5A5A;
        bus.id_imm      = pc + 64'd3;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_uses_rs1 = u1;
        bus.id_uses_rs2 = u2;
        bus.id_ctrl     = ctrl;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; flush = 1'b0; hold = 1'b0;
        set_id(1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 9'd0);
        #1 rst_n = 1'b0;
        #2;
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%0h want=0", bus.ex_valid); end
        total++; if (bus.ex_ctrl !== 9'd0) begin bad++; $display("FAIL reset_ex_ctrl got=%0h want=0", bus.ex_ctrl); end
        total++; if (bus.ex_pc !== 64'd0) begin bad++; $display("FAIL reset_ex_pc got=%0h want=0", bus.ex_pc); end
        total++; if (stall_count !== 2'd0) begin bad++; $display("FAIL reset_stall_count got=%0d want=0", stall_count); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", bus.stall); end
        #5 rst_n = 1'b1;
    endtask

    task automatic test_pass_through();
        set_id(1'b1, 64'h100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 9'h181);
        tick();
        total++; if (bus.ex_pc !== 64'h100) begin bad++; $display("FAIL pass_ex_pc got=%0h want=100", bus.ex_pc); end
        total++; if (bus.ex_rd !== 5'd5) begin bad++; $display("FAIL pass_ex_rd got=%0d want=5", bus.ex_rd); end
        total++; if (bus.ex_ctrl !== 9'h181) begin bad++; $display("FAIL pass_ex_ctrl got=%0h want=181", bus.ex_ctrl); end
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL pass_ex_valid got=%0b want=1", bus.ex_valid); end
        total++; if (bus.ex_imm !== 64'h103) begin bad++; $display("FAIL pass_ex_imm got=%0h want=103", bus.ex_imm); end
    endtask

    task automatic test_load_use();
        // ld x6 ; add x7,x6,x1
        set_id(1'b1, 64'h104, 5'd2, 5'd0, 5'd6, 1'b0, 1'b0, 9'h180);
        #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL lu_pre_stall got=%0b want=0", bus.stall); end
        tick();
        set_id(1'b1, 64'h108, 5'd6, 5'd1, 5'd7, 1'b1, 1'b1, 9'h100);
        #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b want=1", bus.stall); end
        tick();
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble_valid got=%0b want=0", bus.ex_valid); end
        total++; if (bus.ex_ctrl !== 9'd0) begin bad++; $display("FAIL lu_bubble_ctrl got=%0h want=0", bus.ex_ctrl); end
        total++; if (stall_count !== 2'd1) begin bad++; $display("FAIL lu_count got=%0d want=1", stall_count); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL lu_stall_clear got=%0b want=0", bus.stall); end
        tick();
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL lu_add_valid got=%0b want=1", bus.ex_valid); end
        total++; if (bus.ex_rs1 !== 5'd6) begin bad++; $display("FAIL lu_add_rs1 got=%0d want=6", bus.ex_rs1); end
        total++; if (bus.ex_pc !== 64'h108) begin bad++; $display("FAIL lu_add_pc got=%0h want=108", bus.ex_pc); end
        total++; if (stall_count !== 2'd1) begin bad++; $display("FAIL lu_count_hold got=%0d want=1", stall_count); end
    endtask

    task automatic test_no_false_hazard();
        // ld x6 ; lui x7 (reads nothing, but rs1 field happens to be 6)
        set_id(1'b1, 64'h10c, 5'd2, 5'd0, 5'd6, 1'b0, 1'b0, 9'h180);
        tick();
        set_id(1'b1, 64'h110, 5'd6, 5'd6, 5'd7, 1'b0, 1'b0, 9'h100);
        #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL nfh_lui_stall got=%0b want=0", bus.stall); end
        tick();
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL nfh_lui_valid got=%0b want=1", bus.ex_valid); end
        total++; if (stall_count !== 2'd1) begin bad++; $display("FAIL nfh_lui_count got=%0d want=1", stall_count); end
        // ld x0 ; reader of x0
        set_id(1'b1, 64'h114, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 9'h180);
        tick();
        set_id(1'b1, 64'h118, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 9'h100);
        #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL nfh_x0_stall got=%0b want=0", bus.stall); end
        tick();
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL nfh_x0_valid got=%0b want=1", bus.ex_valid); end
        total++; if (stall_count !== 2'd1) begin bad++; $display("FAIL nfh_x0_count got=%0d want=1", stall_count); end
    endtask

    task automatic test_flush_priority();
        set_id(1'b1, 64'h11c, 5'd2, 5'd0, 5'd6, 1'b0, 1'b0, 9'h180);
        tick();
        set_id(1'b1, 64'h120, 5'd6, 5'd1, 5'd7, 1'b1, 1'b0, 9'h100);
        flush = 1'b1;
        #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0b want=0", bus.stall); end
        tick();
        flush = 1'b0;
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", bus.ex_valid); end
        total++; if (bus.ex_ctrl !== 9'd0) begin bad++; $display("FAIL flush_ctrl got=%0h want=0", bus.ex_ctrl); end
        total++; if (stall_count !== 2'd1) begin bad++; $display("FAIL flush_count got=%0d want=1", stall_count); end
    endtask

    task automatic test_hold();
        set_id(1'b1, 64'h124, 5'd2, 5'd0, 5'd6, 1'b0, 1'b0, 9'h180);
        tick();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 64'h200 + 64'(i * 4), 5'd6, 5'd1, 5'd7, 1'b1, 1'b0, 9'h100);
            #1;
            total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL hold_stall[%0d] got=%0b want=1", i, bus.stall); end
            tick();
            total++; if (bus.ex_pc !== 64'h124) begin bad++; $display("FAIL hold_ex_pc[%0d] got=%0h want=124", i, bus.ex_pc); end
            total++; if (bus.ex_ctrl !== 9'h180) begin bad++; $display("FAIL hold_ex_ctrl[%0d] got=%0h want=180", i, bus.ex_ctrl); end
            total++; if (stall_count !== 2'd1) begin bad++; $display("FAIL hold_count[%0d] got=%0d want=1", i, stall_count); end
        end
        hold = 1'b0;
        set_id(1'b1, 64'h128, 5'd6, 5'd1, 5'd7, 1'b1, 1'b0, 9'h100);
        #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL hold_release_stall got=%0b want=1", bus.stall); end
        tick();
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL hold_bubble_valid got=%0b want=0", bus.ex_valid); end
        total++; if (stall_count !== 2'd2) begin bad++; $display("FAIL hold_bubble_count got=%0d want=2", stall_count); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL hold_one_bubble got=%0b want=0", bus.stall); end
        tick();
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL hold_refill_valid got=%0b want=1", bus.ex_valid); end
        total++; if (bus.ex_pc !== 64'h128) begin bad++; $display("FAIL hold_refill_pc got=%0h want=128", bus.ex_pc); end
        total++; if (stall_count !== 2'd2) begin bad++; $display("FAIL hold_refill_count got=%0d want=2", stall_count); end
    endtask

    task automatic test_back_to_back();
        // Two more load-use pairs via rs2; the 2-bit counter goes 2 -> 3 -> 3.
        for (int i = 0; i < 2; i++) begin
            set_id(1'b1, 64'h300 + 64'(i * 16), 5'd2, 5'd0, 5'd9, 1'b0, 1'b0, 9'h180);
            tick();
            set_id(1'b1, 64'h304 + 64'(i * 16), 5'd3, 5'd9, 5'd10, 1'b1, 1'b1, 9'h100);
            #1;
            total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL b2b_stall[%0d] got=%0b want=1", i, bus.stall); end
            tick();
            total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL b2b_bubble[%0d] got=%0b want=0", i, bus.ex_valid); end
            total++; if (stall_count !== 2'd3) begin bad++; $display("FAIL b2b_count[%0d] got=%0d want=3", i, stall_count); end
            tick();
            total++; if (bus.ex_rs2 !== 5'd9) begin bad++; $display("FAIL b2b_rs2[%0d] got=%0d want=9", i, bus.ex_rs2); end
            total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%0b want=1", i, bus.ex_valid); end
        end
    endtask

    task automatic test_reset_mid_stall();
        set_id(1'b1, 64'h400, 5'd2, 5'd0, 5'd6, 1'b0, 1'b0, 9'h180);
        tick();
        set_id(1'b1, 64'h404, 5'd6, 5'd1, 5'd7, 1'b1, 1'b0, 9'h100);
        #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL rms_pre_stall got=%0b want=1", bus.stall); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL rms_valid got=%0b want=0", bus.ex_valid); end
        total++; if (bus.ex_ctrl !== 9'd0) begin bad++; $display("FAIL rms_ctrl got=%0h want=0", bus.ex_ctrl); end
        total++; if (bus.ex_rd !== 5'd0) begin bad++; $display("FAIL rms_rd got=%0d want=0", bus.ex_rd); end
        total++; if (stall_count !== 2'd0) begin bad++; $display("FAIL rms_count got=%0d want=0", stall_count); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rms_stall got=%0b want=0", bus.stall); end
        #2 rst_n = 1'b1;
        tick();
        total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL rms_refill_valid got=%0b want=1", bus.ex_valid); end
        total++; if (bus.ex_pc !== 64'h404) begin bad++; $display("FAIL rms_refill_pc got=%0h want=404", bus.ex_pc); end
        total++; if (bus.ex_ctrl !== 9'h100) begin bad++; $display("FAIL rms_refill_ctrl got=%0h want=100", bus.ex_ctrl); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_false_hazard();
        test_flush_priority();
        test_hold();
        test_back_to_back();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage 64-bit RISC-V core, with integrated load-use hazard detection and bubble insertion.
- Registers decoded operands and control from ID and presents them to EX.
- Its ex_rs1/ex_rs2 outputs feed the EX-stage forwarding unit directly.
- Generates the stall that freezes PC and IF/ID, and counts stall cycles for performance monitoring.

Parameters:
- XLEN, 64, datapath width of PC, operands and immediate.
- CNT_W, 32, width of the saturating stall counter.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID holds a real instruction
- id_pc  input  XLEN  PC of the ID instruction
- id_rs1_data  input  XLEN  register-file read data for rs1
- id_rs2_data  input  XLEN  register-file read data for rs2
- id_imm  input  XLEN  sign-extended immediate
- id_rs1  input  5  source register 1 index
- id_rs2  input  5  source register 2 index
- id_rd  input  5  destination register index
- id_uses_rs1  input  1  instruction reads rs1
- id_uses_rs2  input  1  instruction reads rs2
- id_ctrl  input  9  {reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src, alu_op[2:0]}
- flush  input  1  branch/jump taken, resolved downstream; kill the ID instruction
- hold  input  1  global freeze (memory wait); all state held
- stall  output  1  load-use stall request to PC and IF/ID (combinational)
- ex_valid  output  1  EX holds a real instruction
- ex_pc  output  XLEN  registered PC
- ex_rs1_data  output  XLEN  registered rs1 data
- ex_rs2_data  output  XLEN  registered rs2 data
- ex_imm  output  XLEN  registered immediate
- ex_rs1  output  5  registered rs1 index, to forwarding unit
- ex_rs2  output  5  registered rs2 index, to forwarding unit
- ex_rd  output  5  registered rd index
- ex_ctrl  output  9  registered control bundle
- stall_count  output  CNT_W  number of cycles a load-use bubble was inserted

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0, including ex_valid, ex_ctrl and stall_count. stall is 0 because ex_valid=0.
- Hazard condition:
  - load_use = ex_valid & ex_ctrl.mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)) & id_valid.
  - stall = load_use & ~flush. A flushed ID instruction never stalls.
- Register update on each rising clk, evaluated in priority order:
  1. hold=1: all registers keep their values. stall_count is unchanged. stall is still driven combinationally.
  2. flush=1: bubble. ex_valid=0 and ex_ctrl=0. Data, index and PC fields load from ID; they are don't-care for verification but must be deterministic.
  3. load_use=1: bubble, same as flush. stall_count increments and saturates at all-ones.
  4. Otherwise: load all ID fields. ex_valid=id_valid. ex_ctrl=id_ctrl when id_valid=1, else 0.
- A bubble always has reg_write=0 and mem_read=0, so downstream forwarding and hazard logic ignore it.
- Latency: 1 cycle from ID to EX outputs.
- Back-to-back load-use: after one bubble, EX holds the bubble, so the load is in MEM and load_use clears. Stall lasts exactly 1 cycle per load-use pair.
- rd=x0: a load to x0 never causes a stall.
- flush together with load_use: flush wins, stall=0, no count increment.
- hold together with flush or load_use: nothing changes. The condition is re-evaluated once hold drops.
- Reset asserted mid-stall: outputs clear immediately. After reset the pipe refills normally.

Test Plan:
- Reset: rst_n=0 mid-run with ex_ctrl nonzero -> all outputs 0 immediately, without waiting for a clock edge; stall=0.
- Pass-through: id_valid=1, id_pc=0x100, id_rd=5, id_ctrl=0x181 -> next cycle ex_pc=0x100, ex_rd=5, ex_ctrl=0x181, ex_valid=1.
- Load-use: EX holds ld x6 (mem_read=1, rd=6); ID add x7,x6,x1 with uses_rs1=1 -> stall=1 for 1 cycle, next ex_valid=0 and ex_ctrl=0, stall_count=1. Following cycle the add enters EX with ex_rs1=6.
- No false hazard: same load; ID is lui x7 with uses_rs1=0 and uses_rs2=0, id_rs1=6 -> stall=0, stall_count unchanged. Separately, ld x0 followed by a reader of x0 -> stall=0.
- Flush priority: load_use and flush both 1 -> stall=0, next ex_valid=0, stall_count unchanged.
- Hold: hold=1 for 3 cycles with changing ID inputs and load_use=1 -> EX outputs and stall_count frozen, stall=1 throughout. After hold drops, exactly one bubble is inserted and stall_count increments by 1.
